nonce_reporter: RTL and testbench

NONCE_REPORTER -- requirements
Module: nonce_reporter

---
 rtl/nonce_reporter.sv | 133 +++++++++++++
 tb/tb_nonce_reporter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nonce_reporter.sv
// Golden-nonce reporter: queues nonces from the miner core and streams framed bytes downstream.
// Optional build macro NONCE_REPORTER_CHECKSUM_EN appends an XOR checksum byte to each frame.
//
// state | meaning
// IDLE  | no frame in progress; pops the FIFO head when one is queued
// SEND  | presenting frame bytes on tx_data/tx_valid, advancing on tx_ready
module nonce_reporter #(
    parameter int         FIFO_DEPTH_LOG2 = 2,
    parameter logic [7:0] SYNC_BYTE       = 8'hA5
) (
    input  logic        hash_clk,
    input  logic        reset_n,
    input  logic        golden_nonce_valid,
    input  logic [31:0] golden_nonce,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] drop_count
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
`ifdef NONCE_REPORTER_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [2:0]             byte_idx;
    logic [31:0]            frame;
    logic [15:0]            drop_cnt;
    logic [31:0]            fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2:0] rd_ptr;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   drop;
    logic                   pop;

    function automatic logic [7:0] frame_byte(input logic [31:0] f, input logic [2:0] i);
        logic [7:0] b;
        case (i)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = f[31:24];
            3'd2:    b = f[23:16];
            3'd3:    b = f[15:8];
            3'd4:    b = f[7:0];
`ifdef NONCE_REPORTER_CHECKSUM_EN
            3'd5:    b = f[31:24] ^ f[23:16] ^ f[15:8] ^ f[7:0];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                        (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);

    // Full is judged before any same-cycle pop, so a pop never makes room for this push.
    assign push = golden_nonce_valid && !fifo_full;
    assign drop = golden_nonce_valid && fifo_full;
    assign pop  = (state == IDLE) && !fifo_empty;

    assign busy       = !fifo_empty || (state == SEND);
    assign drop_count = drop_cnt;

    always_ff @(posedge hash_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= golden_nonce;
        end
    end

    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge hash_clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_idx <= 3'd0;
            frame    <= 32'h0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        frame    <= fifo_mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
                        byte_idx <= 3'd0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_valid) begin
                        tx_valid <= 1'b1;
                        tx_data  <= frame_byte(frame, byte_idx);
                    end else if (tx_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx_data  <= frame_byte(frame, byte_idx + 3'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_reporter.sv
// Directed bench for nonce_reporter: latency, framing, backpressure, overflow, saturation, reset.
module tb_nonce_reporter;

`ifdef NONCE_REPORTER_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    logic        hash_clk;
    logic        reset_n;
    logic        golden_nonce_valid;
    logic [31:0] golden_nonce;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] drop_count;

    int tests;
    int fails;

    nonce_reporter #(.FIFO_DEPTH_LOG2(2), .SYNC_BYTE(8'hA5)) dut (
        .hash_clk           (hash_clk),
        .reset_n            (reset_n),
        .golden_nonce_valid (golden_nonce_valid),
        .golden_nonce       (golden_nonce),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .busy               (busy),
        .drop_count         (drop_count)
    );

    initial begin
        hash_clk = 1'b0;
        forever #5 hash_clk = ~hash_clk;
    end

    task automatic tick();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for tx_valid, then expects the whole frame with tx_ready held high.
    task automatic expect_frame(input string tag, input logic [31:0] nonce);
        logic [7:0] exp [6];
        int n;
        exp[0] = 8'hA5;
        exp[1] = nonce[31:24];
        exp[2] = nonce[23:16];
        exp[3] = nonce[15:8];
        exp[4] = nonce[7:0];
        exp[5] = nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
        n = 0;
        while (!tx_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_start"}, {31'd0, tx_valid}, 32'd1);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("%s_b%0d", tag, i), {24'd0, tx_data}, {24'd0, exp[i]});
            tick();
        end
        check({tag, "_end"}, {31'd0, tx_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        golden_nonce_valid = 1'b0;
        golden_nonce = 32'h0;
        tx_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_drop", {16'd0, drop_count}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Single nonce, exact two-cycle latency then consecutive bytes.
        tx_ready = 1'b1;
        golden_nonce_valid = 1'b1;
        golden_nonce = 32'h1dac2b7c;
        tick();
        golden_nonce_valid = 1'b0;
        check("lat_e0_valid", {31'd0, tx_valid}, 32'd0);
        check("lat_e0_busy", {31'd0, busy}, 32'd1);
        tick();
        check("lat_e1_valid", {31'd0, tx_valid}, 32'd0);
        tick();
        check("lat_e2_valid", {31'd0, tx_valid}, 32'd1);
        expect_frame("f1", 32'h1dac2b7c);
        check("f1_busy_after", {31'd0, busy}, 32'd0);

        // Backpressure while 8'hAC is presented.
        golden_nonce_valid = 1'b1;
        tick();
        golden_nonce_valid = 1'b0;
        tick();
        tick();
        check("bp_a5", {24'd0, tx_data}, 32'h000000A5);
        tick();
        check("bp_1d", {24'd0, tx_data}, 32'h0000001D);
        tick();
        check("bp_ac", {24'd0, tx_data}, 32'h000000AC);
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold%0d_data", i), {24'd0, tx_data}, 32'h000000AC);
            check($sformatf("bp_hold%0d_valid", i), {31'd0, tx_valid}, 32'd1);
        end
        tx_ready = 1'b1;
        tick();
        check("bp_2b", {24'd0, tx_data}, 32'h0000002B);
        tick();
        check("bp_7c", {24'd0, tx_data}, 32'h0000007C);
        tick();
`ifdef NONCE_REPORTER_CHECKSUM_EN
        check("bp_e6", {24'd0, tx_data}, 32'h000000E6);
        tick();
`endif
        check("bp_end_valid", {31'd0, tx_valid}, 32'd0);

        // Overflow: seven back-to-back pulses with the sink stalled.
        tx_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            golden_nonce_valid = 1'b1;
            golden_nonce = k;
            tick();
        end
        golden_nonce_valid = 1'b0;
        check("ovf_drop", {16'd0, drop_count}, 32'd2);
        check("ovf_busy", {31'd0, busy}, 32'd1);
        check("ovf_head", {24'd0, tx_data}, 32'h000000A5);
        tx_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            expect_frame($sformatf("ovf_f%0d", k), k);
        end
        check("ovf_drain_busy", {31'd0, busy}, 32'd0);
        check("ovf_drop_keep", {16'd0, drop_count}, 32'd2);

        // Saturation of the drop counter.
        tx_ready = 1'b0;
        force dut.drop_cnt = 16'hFFFE;
        #1;
        release dut.drop_cnt;
        check("sat_forced", {16'd0, drop_count}, 32'h0000FFFE);
        for (int k = 1; k <= 8; k++) begin
            golden_nonce_valid = 1'b1;
            golden_nonce = 32'h100 + k;
            tick();
            if (k == 6) check("sat_first", {16'd0, drop_count}, 32'h0000FFFF);
        end
        golden_nonce_valid = 1'b0;
        check("sat_final", {16'd0, drop_count}, 32'h0000FFFF);

        tx_ready = 1'b1;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("sat_drain_busy", {31'd0, busy}, 32'd0);

        // Reset mid-frame at byte index 2 with two entries queued.
        tx_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            golden_nonce_valid = 1'b1;
            golden_nonce = 32'h11223344 + k;
            tick();
        end
        golden_nonce_valid = 1'b0;
        check("mid_a5", {24'd0, tx_data}, 32'h000000A5);
        tx_ready = 1'b1;
        tick();
        tick();
        check("mid_idx2", {24'd0, tx_data}, 32'h00000022);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_drop", {16'd0, drop_count}, 32'd0);
        check("mid_rst_data", {24'd0, tx_data}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_valid || busy) seen = 1'b1;
        end
        check("mid_no_resume", {31'd0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
